// File: rtl/sample_demultiplexer.sv
// Reassembles a least-significant-byte-first byte stream into SAMPLE_BYTES-wide samples.
// Assembly and holding registers are separate. Define SAMPLE_DEMUX_TIMEOUT_EN to add the idle-timeout resync.
module sample_demultiplexer #(
    parameter int SAMPLE_BYTES   = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      byte_rdy,
    input  logic [7:0]                byte_in,
    output logic                      byte_ack,
    output logic                      sample_rdy,
    output logic [8*SAMPLE_BYTES-1:0] sample,
    input  logic                      sample_ack,
    output logic [7:0]                resync_count
);
    // state   | meaning
    // COLLECT | accepting bytes: idx below last, or holding register free
    // STALL   | last byte pending while holding register is full and not acked

    localparam int W = 8 * SAMPLE_BYTES;
    localparam int IDX_W = $clog2(SAMPLE_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_BYTES - 1);

    if (SAMPLE_BYTES < 2) begin : g_bad_width
        $error("sample_demultiplexer needs at least two bytes per sample");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sample_demultiplexer timeout must be at least one cycle");
    end

    typedef enum logic {COLLECT, STALL} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [W-1:0]     assembly, assembly_nxt, sample_nxt;
    logic             sample_rdy_nxt;
    logic             transfer, last, timeout_fire;

    // state mirrors (idx == LAST_IDX && sample_rdy), so a same-cycle ack unblocks the last byte
    always_comb begin
        byte_ack = byte_rdy && reset_n && !flush && (state != STALL || sample_ack);
        transfer = byte_rdy && byte_ack;
        last     = (idx == LAST_IDX);
    end

    always_comb begin
        idx_nxt        = idx;
        assembly_nxt   = assembly;
        sample_nxt     = sample;
        sample_rdy_nxt = sample_rdy;
        if (transfer && last) begin
            sample_nxt     = {byte_in, assembly[W-9:0]};
            sample_rdy_nxt = 1'b1;
        end else if (sample_ack) begin
            sample_rdy_nxt = 1'b0;
        end
        if (flush || timeout_fire) begin
            idx_nxt      = '0;
            assembly_nxt = '0;
        end else if (transfer) begin
            if (last) begin
                idx_nxt      = '0;
                assembly_nxt = '0;
            end else begin
                idx_nxt                  = idx + IDX_W'(1);
                assembly_nxt[8*idx +: 8] = byte_in;
            end
        end
    end

`ifdef SAMPLE_DEMUX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt, idle_cnt_nxt;
    logic [7:0]    resync_q, resync_nxt;

    // a consumer-induced stall is not an upstream stall, so it never counts as idle
    always_comb begin
        timeout_fire = 1'b0;
        idle_cnt_nxt = '0;
        resync_nxt   = resync_q;
        if (idx != '0 && !transfer && !flush && state != STALL) begin
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_fire = 1'b1;
                if (resync_q != 8'hff) begin
                    resync_nxt = resync_q + 8'd1;
                end
            end else begin
                idle_cnt_nxt = idle_cnt + TW'(1);
            end
        end
    end

    assign resync_count = resync_q;
`else
    assign timeout_fire = 1'b0;
    assign resync_count = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= COLLECT;
            idx        <= '0;
            assembly   <= '0;
            sample     <= '0;
            sample_rdy <= 1'b0;
`ifdef SAMPLE_DEMUX_TIMEOUT_EN
            idle_cnt   <= '0;
            resync_q   <= '0;
`endif
        end else begin
            state      <= (idx_nxt == LAST_IDX && sample_rdy_nxt) ? STALL : COLLECT;
            idx        <= idx_nxt;
            assembly   <= assembly_nxt;
            sample     <= sample_nxt;
            sample_rdy <= sample_rdy_nxt;
`ifdef SAMPLE_DEMUX_TIMEOUT_EN
            idle_cnt   <= idle_cnt_nxt;
            resync_q   <= resync_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sample_demultiplexer.sv
// Scoreboard bench for sample_demultiplexer: expected samples are queued as stimulus is driven
// and compared whenever the consumer takes a sample.
module tb_sample_demultiplexer;
    localparam int SB = 6;
    localparam int W  = 8 * SB;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset_n, flush, byte_rdy, byte_ack, sample_rdy, sample_ack;
    logic [7:0]   byte_in, resync_count;
    logic [W-1:0] sample;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           ack_mode = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_demultiplexer #(.SAMPLE_BYTES(SB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .byte_rdy(byte_rdy),
        .byte_in(byte_in), .byte_ack(byte_ack), .sample_rdy(sample_rdy),
        .sample(sample), .sample_ack(sample_ack), .resync_count(resync_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // consumer: ack policy per ack_mode (0 never, 1 always, 2 random); a take happens at the next posedge
    always @(negedge clk) begin
        case (ack_mode)
            0:       sample_ack = 1'b0;
            1:       sample_ack = 1'b1;
            default: sample_ack = 1'($urandom_range(0, 1));
        endcase
        if (reset_n && sample_rdy && sample_ack) begin
            check("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("sample_q", 64'(sample), 64'(exp_q.pop_front()));
        end
    end

    // drives one byte and returns 1 time unit after the posedge that took it
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit done = 1'b0;
        bit taken = 1'b0;
        @(negedge clk);
        byte_rdy = 1'b1;
        byte_in  = b;
        while (!done) begin
            #4;
            taken = byte_ack;
            @(posedge clk);
            if (taken) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 300) begin
                    check("byte_ack_timeout", 64'(taken), 64'd1);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1 byte_rdy = 1'b0;
    endtask

    task automatic send_sample(input logic [W-1:0] s, input bit push);
        if (push) exp_q.push_back(s);
        for (int i = 0; i < SB; i++) send_byte(s[8*i +: 8]);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]  a, b, z, s1, s2;
        logic [63:0]   r;
        logic [7:0]    rs_exp;
        int            c0;

        reset_n = 1'b0;
        flush   = 1'b0;
        byte_rdy = 1'b1;
        byte_in = 8'h5a;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 64'(sample_rdy), 64'd0);
        check("rst_sample", 64'(sample), 64'd0);
        check("rst_resync", 64'(resync_count), 64'd0);
        check("rst_byte_ack", 64'(byte_ack), 64'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        byte_rdy = 1'b0;
        @(posedge clk);
        #1 ack_mode = 1;

        // single sample, acked immediately
        exp_q.push_back(48'hfeeddeadbeed);
        send_byte(8'hed);
        c0 = cyc;
        send_byte(8'hbe); send_byte(8'had); send_byte(8'hde); send_byte(8'hed); send_byte(8'hfe);
        check("t1_rate", 64'(cyc - c0), 64'd5);
        check("t1_rdy", 64'(sample_rdy), 64'd1);
        check("t1_sample", 64'(sample), 64'hfeeddeadbeed);
        @(posedge clk);
        #1 check("t1_rdy_clear", 64'(sample_rdy), 64'd0);

        // back-to-back with consumer stalled
        ack_mode = 0;
        a = 48'h161514131211;
        b = 48'h262524232221;
        exp_q.push_back(a);
        exp_q.push_back(b);
        send_sample(a, 1'b0);
        for (int i = 0; i < SB - 1; i++) send_byte(b[8*i +: 8]);
        @(negedge clk);
        byte_rdy = 1'b1;
        byte_in  = b[47:40];
        repeat (3) begin
            #4 check("t2_stall_ack", 64'(byte_ack), 64'd0);
            @(negedge clk);
        end
        check("t2_hold_rdy", 64'(sample_rdy), 64'd1);
        check("t2_hold", 64'(sample), 64'(a));
        @(posedge clk);
        #1 ack_mode = 1;
        send_byte(b[47:40]);
        check("t2_rdy_kept", 64'(sample_rdy), 64'd1);
        check("t2_reload", 64'(sample), 64'(b));
        @(posedge clk);
        #1 check("t2_rdy_clear", 64'(sample_rdy), 64'd0);

        // flush drops a partial sample
        send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc);
        @(negedge clk);
        flush    = 1'b1;
        byte_rdy = 1'b1;
        byte_in  = 8'h99;
        #4 check("t3_flush_ack", 64'(byte_ack), 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        byte_rdy = 1'b0;
        send_sample(48'h060504030201, 1'b1);
        check("t3_sample", 64'(sample), 64'h060504030201);

        // reset mid-sample with a held sample
        @(posedge clk);
        #1 ack_mode = 0;
        send_sample(48'h363534333231, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
        check("t4_pre_rdy", 64'(sample_rdy), 64'd1);
        @(negedge clk);
        reset_n  = 1'b0;
        byte_rdy = 1'b1;
        byte_in  = 8'h55;
        #4 check("t4_rst_ack", 64'(byte_ack), 64'd0);
        @(posedge clk);
        #1;
        check("t4_rst_rdy", 64'(sample_rdy), 64'd0);
        check("t4_rst_sample", 64'(sample), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n  = 1'b1;
        byte_rdy = 1'b0;
        @(posedge clk);
        #1 ack_mode = 1;
        z = 48'h4e4d4c4b4a49;
        send_sample(z, 1'b1);
        check("t4_fresh", 64'(sample), 64'(z));

        // random byte gaps and random consumer acks
        @(posedge clk);
        #1 ack_mode = 2;
        for (int s = 0; s < 25; s++) begin
            r = {$urandom, $urandom};
            a = r[W-1:0];
            exp_q.push_back(a);
            for (int i = 0; i < SB; i++) begin
                repeat ($urandom_range(0, 7)) @(posedge clk);
                send_byte(a[8*i +: 8]);
            end
        end
        #1 ack_mode = 1;
        drain();

        // idle partial sample: timeout resync or indefinite persistence
        send_byte(8'h10);
        send_byte(8'h20);
        repeat (TO - 1) @(posedge clk);
        #1 check("t6_pre_timeout", 64'(resync_count), 64'd0);
        @(posedge clk);
        #1;
`ifdef SAMPLE_DEMUX_TIMEOUT_EN
        rs_exp = 8'd1;
        check("t6_resync", 64'(resync_count), 64'd1);
        send_sample(48'hc6c5c4c3c2c1, 1'b1);
        check("t6_after_resync", 64'(sample), 64'hc6c5c4c3c2c1);
`else
        rs_exp = 8'd0;
        check("t6_resync", 64'(resync_count), 64'd0);
        exp_q.push_back(48'hc4c3c2c12010);
        send_byte(8'hc1); send_byte(8'hc2); send_byte(8'hc3); send_byte(8'hc4);
        check("t6_persist", 64'(sample), 64'hc4c3c2c12010);
`endif
        drain();

        // long consumer stall must not count as upstream idle
        ack_mode = 0;
        s1 = 48'h717273747576;
        s2 = 48'h818283848586;
        exp_q.push_back(s1);
        exp_q.push_back(s2);
        send_sample(s1, 1'b0);
        for (int i = 0; i < SB - 1; i++) send_byte(s2[8*i +: 8]);
        @(negedge clk);
        byte_rdy = 1'b1;
        byte_in  = s2[47:40];
        repeat (100) @(posedge clk);
        #1;
        check("t6_stall_resync", 64'(resync_count), 64'(rs_exp));
        check("t6_stall_ack", 64'(byte_ack), 64'd0);
        ack_mode = 1;
        send_byte(s2[47:40]);
        check("t6_stall_sample", 64'(sample), 64'(s2));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
